// File: rtl/alu_issue_pkg.sv
// Shared widths and issue FSM state codes for alu_issue and its register file.
package alu_issue_pkg;

  localparam int N_DEFAULT    = 8;
  localparam int NREG_DEFAULT = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

endpackage

// File: rtl/alu_pkg.sv
// Team ALU function codes, shared by every block that drives the ALU.
package alu_pkg;

  localparam logic RADD = 1'b0;
  localparam logic RMUL = 1'b1;

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file: R0 is hardwired to zero, two combinational source ports,
// one synchronous write port and a combinational debug read port.
module regfile
  import alu_issue_pkg::*;
#(
  parameter int n    = N_DEFAULT,
  parameter int NREG = NREG_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(NREG)-1:0] rs_addr,
  output logic [n-1:0]            rs_data,
  input  logic [$clog2(NREG)-1:0] rt_addr,
  output logic [n-1:0]            rt_data,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [n-1:0]            wr_data,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [n-1:0]            dbg_data
);

  localparam int AW = $clog2(NREG);

  // No storage for R0, so a write to address 0 simply matches nothing.
  logic [n-1:0] regs [1:NREG-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_addr == AW'(i)) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rs_data  = '0;
    rt_data  = '0;
    dbg_data = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs_addr == AW'(i)) begin
        rs_data = regs[i];
      end
      if (rt_addr == AW'(i)) begin
        rt_data = regs[i];
      end
      if (dbg_addr == AW'(i)) begin
        dbg_data = regs[i];
      end
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Serialised single-instruction issue stage: reads operands, hands them to the
// external ALU, captures the result and writes it back (IDLE -> EXEC -> WB).
module alu_issue
  import alu_pkg::*;
  import alu_issue_pkg::*;
#(
  parameter int n    = N_DEFAULT,
  parameter int NREG = NREG_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_func,
  input  logic [$clog2(NREG)-1:0] in_rd,
  input  logic [$clog2(NREG)-1:0] in_rs,
  input  logic [$clog2(NREG)-1:0] in_rt,
  input  logic                    in_imm_sel,
  input  logic [n-1:0]            in_imm,
  output logic [n-1:0]            alu_a,
  output logic [n-1:0]            alu_b,
  output logic                    alu_func,
  input  logic [n-1:0]            alu_result,
  output logic                    done,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [n-1:0]            dbg_data
);

  localparam int AW = $clog2(NREG);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [AW-1:0] rd_q;
  logic [n-1:0]  result_q;
  logic [n-1:0]  rs_data;
  logic [n-1:0]  rt_data;
  logic          accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign done     = (state == WB);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operands are captured only on accept and held until the next accept.
  // Issue is serialised, so sources always see committed register contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_func <= RADD;
      rd_q     <= '0;
    end else if (accept) begin
      alu_a    <= rs_data;
      alu_b    <= in_imm_sel ? in_imm : rt_data;
      alu_func <= in_func;
      rd_q     <= in_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
    end else if (state == EXEC) begin
      result_q <= alu_result;
    end
  end

  regfile #(
    .n    (n),
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs_addr  (in_rs),
    .rs_data  (rs_data),
    .rt_addr  (in_rt),
    .rt_data  (rt_data),
    .we       (done),
    .wr_addr  (rd_q),
    .wr_data  (result_q),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule
